// File: rtl/vpipe_pkg.sv
// vpipe_pkg: shared constants and helpers for the parameterised vector pipeline.
package vpipe_pkg;

    localparam int VPIPE_MAX_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipe_valid_stage.sv
// pipe_valid_stage: one payload register plus valid bit with enable, squash and optional bubble fill.
module pipe_valid_stage #(
    parameter int WIDTH    = 8,
    parameter bit COLLAPSE = 1'b0,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] src,
    input  logic             src_v,
    input  logic             en,
    input  logic             squash,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             valid_nxt
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             load;

    always_comb begin
        load    = en | (COLLAPSE & ~valid_q);
        data_d  = squash ? (CLR_DATA ? '0 : data_q) : load ? src : data_q;
        valid_d = squash ? 1'b0 : load ? src_v : valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // next-state valid feeds the occupancy count so it lines up with valid
    assign valid_nxt = valid_d;
    assign data      = data_q;
    assign valid     = valid_q;

endmodule

// File: rtl/pipe_valid_param.sv
// pipe_valid_param: DEPTH-stage payload+valid pipeline with per-stage enable/squash,
// optional bubble fill, and registered occupancy.
module pipe_valid_param
    import vpipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter bit COLLAPSE = 1'b0,
    parameter bit CLR_DATA = 1'b1,
    parameter int CNT_W    = clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    input  logic [DEPTH-1:0]         en,
    input  logic [DEPTH-1:0]         squash,
    output logic [WIDTH*(DEPTH+1)-1:0] q,
    output logic [DEPTH:0]           q_valid,
    output logic [CNT_W-1:0]         occ,
    output logic                     empty
);

    logic [WIDTH-1:0] st_data [DEPTH];
    logic [DEPTH-1:0] st_valid, st_nxt;
    logic [CNT_W-1:0] occ_d, occ_q;
    logic             empty_d, empty_q;

    if (DEPTH < 1 || DEPTH > VPIPE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_valid_param: DEPTH out of range");
    end

    pipe_valid_stage #(.WIDTH(WIDTH), .COLLAPSE(COLLAPSE), .CLR_DATA(CLR_DATA)) u_st0 (
        .clk(clk), .reset(reset), .src(d), .src_v(d_valid), .en(en[0]), .squash(squash[0]),
        .data(st_data[0]), .valid(st_valid[0]), .valid_nxt(st_nxt[0])
    );

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        pipe_valid_stage #(.WIDTH(WIDTH), .COLLAPSE(COLLAPSE), .CLR_DATA(CLR_DATA)) u_st (
            .clk(clk), .reset(reset), .src(st_data[g-1]), .src_v(st_valid[g-1]),
            .en(en[g]), .squash(squash[g]),
            .data(st_data[g]), .valid(st_valid[g]), .valid_nxt(st_nxt[g])
        );
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign q[(g+1)*WIDTH +: WIDTH] = st_data[g];
    end

    assign q[WIDTH-1:0] = d;
    assign q_valid      = {st_valid, d_valid};

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) occ_d = occ_d + CNT_W'(st_nxt[i]);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= '0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            empty_q <= empty_d;
        end
    end

    assign occ   = occ_q;
    assign empty = empty_q;

endmodule
